// File: rtl/gate_sequencer_pkg.sv
// Shared definitions for the gate sequencer: FSM encoding and the parameter
// defaults that the register map also picks up.
package gate_seq_pkg;

    localparam int CNT_W_DEF      = 8;
    localparam int TIME_W_DEF     = 24;
    localparam int SHOT_W_DEF     = 16;
    localparam int SETTLE_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GATE_ON  = 3'd1;
    localparam logic [2:0] ST_SETTLE_W = 3'd2;
    localparam logic [2:0] ST_CAPTURE  = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        GATE_ON  = ST_GATE_ON,
        SETTLE_W = ST_SETTLE_W,
        CAPTURE  = ST_CAPTURE,
        GAP      = ST_GAP
    } state_t;

endpackage

// File: rtl/gate_sequencer_if.sv
// Control, counter and result-readout signals of the gate sequencer.
// master = PS/register side driving the block, slave = the sequencer itself.
interface gate_sequencer_if
    import gate_seq_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TIME_W     = TIME_W_DEF,
    parameter int SHOT_W     = SHOT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    logic                            start;
    logic                            stop;
    logic [TIME_W-1:0]               gate_len;
    logic [TIME_W-1:0]               gate_period;
    logic [SHOT_W-1:0]               n_shots;
    logic                            gate;
    logic [CNT_W-1:0]                count_in;
    logic                            rd_en;
    logic [CNT_W-1:0]                rd_data;
    logic                            rd_valid;
    logic [$clog2(FIFO_DEPTH):0]     level;
    logic                            intr;
    logic                            intr_ack;
    logic                            overflow;
    logic                            busy;

    modport master (
        output start, stop, gate_len, gate_period, n_shots, count_in, rd_en, intr_ack,
        input  gate, rd_data, rd_valid, level, intr, overflow, busy
    );

    modport slave (
        input  start, stop, gate_len, gate_period, n_shots, count_in, rd_en, intr_ack,
        output gate, rd_data, rd_valid, level, intr, overflow, busy
    );

endinterface

// File: rtl/gate_sequencer_fifo.sv
// First-word-fall-through result buffer. A push is refused whenever the FIFO
// is full at the start of the cycle, even if a pop happens alongside it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: rd_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/gate_sequencer.sv
// Generates the PMT GATE window train, samples the counter after each window
// and buffers results for software; raises a level interrupt per batch.
module gate_sequencer
    import gate_seq_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TIME_W     = TIME_W_DEF,
    parameter int SHOT_W     = SHOT_W_DEF,
    parameter int SETTLE     = SETTLE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    gate_sequencer_if.slave  bus
);
    // Two spare bits so len + SETTLE + 2 can never wrap.
    localparam int TW = TIME_W + 2;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmr_q;
    logic [TW-1:0]     len_q, peff_q;
    logic [TW-1:0]     len_c, min_p, period_c, peff_c;
    logic [SHOT_W-1:0] nshots_q, shot_q, shot_inc;
    logic [CNT_W-1:0]  cap_q;
    logic              gate_q, intr_q, ovf_q;
    logic              go, wr_en, intr_set;
    logic              fifo_full, fifo_empty;

    assign len_c    = (bus.gate_len == '0) ? TW'(1) : TW'(bus.gate_len);
    assign min_p    = len_c + TW'(SETTLE) + TW'(2);
    assign period_c = TW'(bus.gate_period);
    assign peff_c   = (period_c > min_p) ? period_c : min_p;
    assign shot_inc = shot_q + SHOT_W'(1);
    assign go       = (state_q == IDLE) && bus.start && !bus.stop && (bus.n_shots != '0);

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        intr_set = 1'b0;
        if (state_q != IDLE && bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (go) state_d = GATE_ON;
                GATE_ON:  if (tmr_q == len_q - TW'(1)) state_d = SETTLE_W;
                SETTLE_W: if (tmr_q == len_q + TW'(SETTLE - 1)) state_d = CAPTURE;
                CAPTURE: begin
                    wr_en = 1'b1;
                    if (shot_inc == nshots_q) begin
                        intr_set = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = GAP;
                    end
                end
                GAP:      if (tmr_q == peff_q - TW'(1)) state_d = GATE_ON;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gate_q   <= 1'b0;
            tmr_q    <= '0;
            len_q    <= TW'(1);
            peff_q   <= '0;
            nshots_q <= '0;
            shot_q   <= '0;
            cap_q    <= '0;
            intr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= (state_d == GATE_ON);
            // The timer measures cycles since the current GATE rise.
            tmr_q   <= (state_d == GATE_ON && state_q != GATE_ON) ? '0 : tmr_q + TW'(1);
            if (go) begin
                len_q    <= len_c;
                peff_q   <= peff_c;
                nshots_q <= bus.n_shots;
                shot_q   <= '0;
                ovf_q    <= 1'b0;
            end
            // Sample SETTLE cycles after GATE falls; the push follows in CAPTURE.
            if (state_q == SETTLE_W && state_d == CAPTURE) cap_q <= bus.count_in;
            if (wr_en) begin
                shot_q <= shot_inc;
                if (fifo_full) ovf_q <= 1'b1;
            end
            if (intr_set)          intr_q <= 1'b1;
            else if (bus.intr_ack) intr_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (cap_q),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (bus.level)
    );

    assign bus.gate     = gate_q;
    assign bus.rd_valid = !fifo_empty;
    assign bus.intr     = intr_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: a table of batch configurations plus
// hand-written sequences for abort, edge inputs and asynchronous reset.
module tb_gate_sequencer;
    localparam int CNT_W      = 8;
    localparam int TIME_W     = 24;
    localparam int SHOT_W     = 16;
    localparam int SETTLE     = 4;
    localparam int FIFO_DEPTH = 8;

    typedef struct {
        int len;
        int per;
        int n;
        int e_hi;
        int e_sp;
        int e_lvl;
        int e_ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[4];

    gate_sequencer_if #(
        .CNT_W (CNT_W), .TIME_W (TIME_W), .SHOT_W (SHOT_W), .FIFO_DEPTH (FIFO_DEPTH)
    ) bus ();

    gate_sequencer #(
        .CNT_W (CNT_W), .TIME_W (TIME_W), .SHOT_W (SHOT_W),
        .SETTLE (SETTLE), .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input int len, input int per, input int n);
        bus.gate_len    = TIME_W'(len);
        bus.gate_period = TIME_W'(per);
        bus.n_shots     = SHOT_W'(n);
    endtask

    // Called at a negedge; returns at the next negedge (cycle 1 after START).
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input int n, input bit chk_data);
        for (int i = 0; i < n; i++) begin
            if (chk_data) chk("rd_data", int'(bus.rd_data), 5 + i);
            chk("rd_valid", int'(bus.rd_valid), 1);
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic ack_intr();
        bus.intr_ack = 1'b1;
        @(negedge clk);
        bus.intr_ack = 1'b0;
        chk("intr_after_ack", int'(bus.intr), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, rises, last_rise, first_rise, cur, sp;
        int hi_min, hi_max, sp_min, sp_max, fall_cyc, done_cyc;
        bit prev, to;
        cfg(v.len, v.per, v.n);
        pulse_start();
        cyc = 1; rises = 0; last_rise = 0; first_rise = -1; cur = 0;
        hi_min = 1000000; hi_max = 0; sp_min = 1000000; sp_max = 0;
        fall_cyc = 0; done_cyc = 0; prev = 1'b0; to = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (bus.gate && !prev) begin
                if (rises == 0) first_rise = cyc;
                else begin
                    sp = cyc - last_rise;
                    if (sp < sp_min) sp_min = sp;
                    if (sp > sp_max) sp_max = sp;
                end
                last_rise = cyc;
                rises++;
                cur = 0;
                bus.count_in = CNT_W'(4 + rises);
            end
            if (bus.gate) cur++;
            if (!bus.gate && prev) begin
                if (cur < hi_min) hi_min = cur;
                if (cur > hi_max) hi_max = cur;
                fall_cyc = cyc;
            end
            if (!bus.busy) begin
                done_cyc = cyc;
                to = 1'b0;
                break;
            end
            prev = bus.gate;
            @(negedge clk);
            cyc++;
        end
        chk("batch_timeout", int'(to), 0);
        chk("first_rise", first_rise, 1);
        chk("rises", rises, v.n);
        chk("gate_hi_min", hi_min, v.e_hi);
        chk("gate_hi_max", hi_max, v.e_hi);
        chk("spacing_min", sp_min, v.e_sp);
        chk("spacing_max", sp_max, v.e_sp);
        chk("fall_to_done", done_cyc - fall_cyc, SETTLE + 1);
        chk("intr", int'(bus.intr), 1);
        chk("level", int'(bus.level), v.e_lvl);
        chk("overflow", int'(bus.overflow), v.e_ovf);
        drain(v.e_lvl, 1'b1);
        chk("level_drained", int'(bus.level), 0);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("pop_empty_level", int'(bus.level), 0);
        chk("pop_empty_valid", int'(bus.rd_valid), 0);
        ack_intr();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          len per  n  hi  sp  lvl ovf
        vecs[0] = '{10, 40,  3, 10, 40, 3,  0};  // basic batch
        vecs[1] = '{10,  5,  2, 10, 16, 2,  0};  // undersized period clamped
        vecs[2] = '{ 0, 20,  2,  1, 20, 2,  0};  // zero length -> 1-cycle gate
        vecs[3] = '{ 3,  0, 10,  3,  9, 8,  1};  // overflow, no reads

        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.rd_en = 1'b0; bus.intr_ack = 1'b0;
        bus.count_in = '0;
        cfg(0, 0, 0);
        #1;
        chk("rst_gate", int'(bus.gate), 0);
        chk("rst_intr", int'(bus.intr), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.rd_valid), 0);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_data", int'(bus.rd_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Sticky overflow survives draining, cleared by the next START.
        chk("ovf_sticky", int'(bus.overflow), 1);
        cfg(3, 0, 1);
        pulse_start();
        chk("ovf_cleared", int'(bus.overflow), 0);
        chk("busy_n1", int'(bus.busy), 1);
        repeat (12) @(negedge clk);
        chk("n1_done", int'(bus.busy), 0);
        chk("n1_intr", int'(bus.intr), 1);
        drain(1, 1'b0);
        ack_intr();

        // START with N_SHOTS=0 is ignored.
        cfg(10, 40, 0);
        pulse_start();
        chk("nshots0_busy", int'(bus.busy), 0);
        repeat (5) @(negedge clk);
        chk("nshots0_gate", int'(bus.gate), 0);

        // STOP together with START in IDLE wins.
        cfg(10, 40, 3);
        bus.stop = 1'b1;
        pulse_start();
        bus.stop = 1'b0;
        chk("start_stop_busy", int'(bus.busy), 0);

        // Abort during the second GATE_ON (rises at cycles 1 and 41).
        cfg(10, 40, 3);
        pulse_start();
        repeat (42) @(negedge clk);
        chk("abort_pre_gate", int'(bus.gate), 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("abort_gate", int'(bus.gate), 0);
        chk("abort_busy", int'(bus.busy), 0);
        repeat (60) @(negedge clk);
        chk("abort_gate_idle", int'(bus.gate), 0);
        chk("abort_level", int'(bus.level), 1);
        chk("abort_intr", int'(bus.intr), 0);
        drain(1, 1'b0);

        // INTR_ACK in the same cycle as a new completion: set wins.
        cfg(2, 0, 1);
        pulse_start();
        repeat (12) @(negedge clk);
        chk("intrA", int'(bus.intr), 1);
        pulse_start();
        chk("start_keeps_intr", int'(bus.intr), 1);
        repeat (6) @(negedge clk);
        chk("capture_busy", int'(bus.busy), 1);
        bus.intr_ack = 1'b1;
        @(negedge clk);
        bus.intr_ack = 1'b0;
        chk("ack_vs_set", int'(bus.intr), 1);
        chk("ack_vs_set_busy", int'(bus.busy), 0);
        ack_intr();

        // Asynchronous reset mid-GATE_ON (second rise at cycle 21).
        cfg(10, 20, 2);
        pulse_start();
        repeat (22) @(negedge clk);
        chk("pre_rst_gate", int'(bus.gate), 1);
        chk("pre_rst_level", int'(bus.level), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_gate", int'(bus.gate), 0);
        chk("arst_level", int'(bus.level), 0);
        chk("arst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sequencer.md
# gate_sequencer

Controller that sequences the photon-counting datapath for qubit-state discrimination. It generates a programmable train of GATE windows for the PMT counter and captures the counter's 8-bit result after each window. Results are buffered in a small FIFO for the PS-side inference software, and a level interrupt is raised when a batch of shots is complete. It sits between the PS register interface and the counter / 33 kHz divider pair, replacing the externally driven GATE.

## Interface
- CNT_W, 8: width of captured count.
- TIME_W, 24: width of gate length/period fields, in CLK cycles.
- SHOT_W, 16: width of shot-count field.
- SETTLE, 4: CLK cycles from GATE fall to count sample; must be at least 1.
- FIFO_DEPTH, 8: result buffer entries; must be a power of 2.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse that begins a batch; honoured only in IDLE.
- STOP  in  1  one-cycle pulse that aborts the batch.
- GATE_LEN  in  TIME_W  GATE high time in cycles.
- GATE_PERIOD  in  TIME_W  rise-to-rise spacing in cycles.
- N_SHOTS  in  SHOT_W  shots per batch.
- GATE  out  1  registered gate to the counter and divider.
- COUNT_IN  in  CNT_W  counter's COUNTER output.
- RD_EN  in  1  pop the FIFO head.
- RD_DATA  out  CNT_W  FIFO head, first-word-fall-through.
- RD_VALID  out  1  FIFO not empty.
- LEVEL  out  $clog2(FIFO_DEPTH)+1  entries held.
- INTR  out  1  batch done; level signal.
- INTR_ACK  in  1  clears INTR.
- OVERFLOW  out  1  sticky flag: a sample was dropped.
- BUSY  out  1  FSM not in IDLE.

## Operation
FSM states: IDLE, GATE_ON, SETTLE_W, CAPTURE, GAP.

- **IDLE**
  - START with N_SHOTS≠0: latch GATE_LEN, GATE_PERIOD and N_SHOTS; clear OVERFLOW and the shot counter; go to GATE_ON.
  - START with N_SHOTS=0: ignored.
- **GATE_ON**: GATE=1 for L = max(GATE_LEN,1) cycles, then go to SETTLE_W.
- **SETTLE_W**: GATE=0 for SETTLE cycles, then go to CAPTURE.
- **CAPTURE** (one cycle)
  - Push COUNT_IN into the FIFO and increment the shot counter.
  - If the FIFO is full, drop the sample and set OVERFLOW; the shot still counts.
  - If the shot counter now equals N_SHOTS: set INTR and go to IDLE. Otherwise go to GAP.
- **GAP**: wait until P_eff = max(GATE_PERIOD, L+SETTLE+2) cycles have elapsed since the current GATE rise, then go to GATE_ON. An undersized period is clamped, not an error.
- **STOP** in any non-IDLE state: next state is IDLE and GATE drops the next cycle.
  - The in-flight shot is discarded; no FIFO write, no INTR.
  - Samples already in the FIFO are retained.
- **STOP and START in the same cycle in IDLE**: STOP wins and the batch does not start.
- **INTR**
  - Held high until INTR_ACK, which clears it the next cycle.
  - A new set in the same cycle as INTR_ACK wins.
  - A new START does not clear INTR.
- **FIFO**
  - Simultaneous push and pop is allowed; LEVEL is unchanged.
  - Pop when empty is ignored.
  - A push while full is dropped even if RD_EN is high in the same cycle; a full FIFO is checked before the pop.
- **Config inputs**: may change freely while BUSY; only the values latched at START are used.
- **Arithmetic**: timers use TIME_W+2 bits so L+SETTLE+2 never wraps. Shot counter is SHOT_W bits and compares for equality.

## Timing
- Reset values: GATE=0, INTR=0, OVERFLOW=0, BUSY=0, RD_VALID=0, LEVEL=0, RD_DATA=0. FSM in IDLE.
- START accepted on edge t:
  - GATE=1 and BUSY=1 from cycle t+1.
  - GATE is high for cycles t+1 … t+L.
- COUNT_IN sampled on the edge ending cycle t+L+SETTLE.
  - RD_VALID/LEVEL update the following cycle.
- Next GATE rise at t+1+P_eff.
- Final CAPTURE: INTR=1 and BUSY=0 on the next cycle.
- RD_EN at edge e: RD_DATA shows the next entry from cycle e+1.

## Structure
- Shared package gate_seq_pkg holds:
  - the state encoding localparams;
  - the defaults for CNT_W, TIME_W and SETTLE, reused by the register map.
- One sub-module, sync_fifo: parameterised width/depth, FWFT, with full/empty/level outputs.
- The FSM and timers stay in gate_sequencer.

## Test plan
- **Basic batch**: GATE_LEN=10, GATE_PERIOD=40, N_SHOTS=3, COUNT_IN=shot index+5.
  - Expect three 10-cycle gates with rises 40 cycles apart.
  - FIFO holds 5, 6, 7; INTR rises after the third capture.
- **Clamp**: GATE_LEN=10, GATE_PERIOD=5, SETTLE=4 → rise-to-rise spacing of 16 cycles.
- **Overflow**: N_SHOTS=10, no reads.
  - LEVEL saturates at 8 and OVERFLOW=1.
  - INTR still asserts after 10 shots.
  - The next START clears OVERFLOW.
- **Abort**: STOP during the 2nd GATE_ON.
  - GATE falls the next cycle; LEVEL=1; INTR stays 0.
  - BUSY=0 the cycle after STOP.
- **Edge inputs**:
  - N_SHOTS=0 START → BUSY stays 0.
  - GATE_LEN=0 → 1-cycle gate.
  - INTR_ACK coincident with a new completion → INTR stays 1.
- **Async reset**: RST asserted mid-GATE_ON → GATE=0 and LEVEL=0 immediately, without waiting for a CLK edge.
